mem_stage_reg: RTL



---
 rtl/mem_stage_reg_pkg.sv | 25 ++
 rtl/mem_stage_reg_if.sv | 28 ++
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_stage_reg.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mem_stage_reg_pkg.sv
// Shared constants for the MEM pipeline stage: load-op encoding, exception
// vector layout and the MEM->WB bus width.
package mem_stage_reg_pkg;

  // es_ld_op is one-hot {ld_w, ld_h, ld_hu, ld_b, ld_bu}
  localparam int LD_OP_W   = 5;
  localparam int LD_W_BIT  = 4;
  localparam int LD_H_BIT  = 3;
  localparam int LD_HU_BIT = 2;
  localparam int LD_B_BIT  = 1;
  localparam int LD_BU_BIT = 0;

  localparam int EXC_W    = 16;
  localparam int EXC_INT  = 0;
  localparam int EXC_ADEF = 1;
  localparam int EXC_ALE  = 2;
  localparam int EXC_SYS  = 3;
  localparam int EXC_BRK  = 4;
  localparam int EXC_INE  = 5;
  localparam int EXC_ERTN = 6;

  // {pc, final_result, rf_we, rf_waddr, except}
  localparam int MS_TO_WS_BUS_W = 32 + 32 + 1 + 5 + EXC_W;

endpackage

// File: rtl/mem_stage_reg_if.sv
// EX->MEM payload bus with its allowin back-pressure.
interface mem_stage_reg_if;
  import mem_stage_reg_pkg::*;

  logic               es_to_ms_valid;
  logic               ms_allowin;
  logic [31:0]        es_pc;
  logic [31:0]        es_result;
  logic               es_rf_we;
  logic [4:0]         es_rf_waddr;
  logic               es_res_from_mem;
  logic               es_mem_req;
  logic [LD_OP_W-1:0] es_ld_op;
  logic [EXC_W-1:0]   es_except;
  logic               es_addr_hs;

  modport master (
    output es_to_ms_valid, es_pc, es_result, es_rf_we, es_rf_waddr,
           es_res_from_mem, es_mem_req, es_ld_op, es_except, es_addr_hs,
    input  ms_allowin
  );

  modport slave (
    input  es_to_ms_valid, es_pc, es_result, es_rf_we, es_rf_waddr,
           es_res_from_mem, es_mem_req, es_ld_op, es_except, es_addr_hs,
    output ms_allowin
  );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load-data extraction: selects byte/half/word by address and
// sign- or zero-extends according to the one-hot load op.
module mem_load_align
  import mem_stage_reg_pkg::*;
(
  input  logic [31:0]        rdata,
  input  logic [1:0]         a,
  input  logic [LD_OP_W-1:0] ld_op,
  output logic [31:0]        result
);

  logic        [7:0]  byte_u;
  logic        [15:0] half_u;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_u = rdata[7:0];
    case (a)
      2'd1:    byte_u = rdata[15:8];
      2'd2:    byte_u = rdata[23:16];
      2'd3:    byte_u = rdata[31:24];
      default: byte_u = rdata[7:0];
    endcase
    half_u = a[1] ? rdata[31:16] : rdata[15:0];
    byte_s = signed'(byte_u);
    half_s = signed'(half_u);

    result = rdata;
    if (ld_op[LD_W_BIT])       result = rdata;
    else if (ld_op[LD_H_BIT])  result = 32'(half_s);
    else if (ld_op[LD_HU_BIT]) result = {16'b0, half_u};
    else if (ld_op[LD_B_BIT])  result = 32'(byte_s);
    else if (ld_op[LD_BU_BIT]) result = {24'b0, byte_u};
  end

endmodule

// File: rtl/mem_stage_reg.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data, buffers
// it under WB back-pressure and discards responses of flushed instructions.
// Optional MS_PERF_CNT_EN adds the ms_stall_cnt stall-cycle counter output.
module mem_stage_reg
  import mem_stage_reg_pkg::*;
#(
  parameter int DISCARD_W = 2
)
(
  input  logic               clk,
  input  logic               resetn,
  mem_stage_reg_if.slave     es,
  input  logic               data_sram_data_ok,
  input  logic [31:0]        data_sram_rdata,
  input  logic               except_flush,
  input  logic               ws_allowin,
  output logic               ms_to_ws_valid,
  output logic [31:0]        ms_pc,
  output logic [31:0]        ms_final_result,
  output logic               ms_rf_we,
  output logic [4:0]         ms_rf_waddr,
  output logic [EXC_W-1:0]   ms_except_out,
  output logic               ms_fwd_block
`ifdef MS_PERF_CNT_EN
  ,
  output logic [31:0]        ms_stall_cnt
`endif
);

  localparam int DISC_MAX = (1 << DISCARD_W) - 1;

  logic               vld_p1;
  logic [31:0]        pc_p1;
  logic [31:0]        result_p1;
  logic               rf_we_p1;
  logic [4:0]         rf_waddr_p1;
  logic               load_p1;
  logic               mem_req_p1;
  logic [LD_OP_W-1:0] ld_op_p1;
  logic [EXC_W-1:0]   except_p1;
  logic               data_seen_p1;
  logic               buf_valid_p1;
  logic [31:0]        rdata_buf_p1;
  logic [DISCARD_W-1:0] discard_cnt;

  logic                 resp_take;
  logic                 disc_dec;
  logic                 pend_lost;
  logic [1:0]           flush_add;
  logic [DISCARD_W+1:0] disc_sum;
  logic [DISCARD_W-1:0] disc_next;
  logic                 ms_ready_go;
  logic                 accept;
  logic [31:0]          load_src;
  logic [31:0]          load_data;
  logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus;

  // A response only belongs to the current instruction once all stale ones are gone
  assign resp_take   = data_sram_data_ok & (discard_cnt == '0);
  assign disc_dec    = data_sram_data_ok & (discard_cnt != '0);
  assign ms_ready_go = ~mem_req_p1 | data_seen_p1 | buf_valid_p1 | resp_take;
  assign es.ms_allowin = ~vld_p1 | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = vld_p1 & ms_ready_go & ~except_flush;
  assign accept = es.es_to_ms_valid & es.ms_allowin;

  always_comb begin
    pend_lost = vld_p1 & mem_req_p1 & ~data_seen_p1 & ~resp_take;
    flush_add = except_flush ? (2'(pend_lost) + 2'(es.es_addr_hs)) : 2'd0;
    disc_sum  = (DISCARD_W+2)'(discard_cnt) + (DISCARD_W+2)'(flush_add)
              - (DISCARD_W+2)'(disc_dec);
    disc_next = (disc_sum > (DISCARD_W+2)'(DISC_MAX)) ? DISCARD_W'(DISC_MAX)
                                                      : disc_sum[DISCARD_W-1:0];
  end

  assign load_src = buf_valid_p1 ? rdata_buf_p1 : data_sram_rdata;

  mem_load_align u_align (
    .rdata  (load_src),
    .a      (result_p1[1:0]),
    .ld_op  (ld_op_p1),
    .result (load_data)
  );

  assign ms_fwd_block = vld_p1 & load_p1 & ~(data_seen_p1 | buf_valid_p1 | resp_take);

  assign ms_to_ws_bus = {pc_p1,
                         load_p1 ? load_data : result_p1,
                         rf_we_p1 & vld_p1,
                         rf_waddr_p1,
                         except_p1 & {EXC_W{vld_p1}}};
  assign {ms_pc, ms_final_result, ms_rf_we, ms_rf_waddr, ms_except_out} = ms_to_ws_bus;

  // EX -> MEM stage register and response tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      result_p1    <= '0;
      rf_we_p1     <= 1'b0;
      rf_waddr_p1  <= '0;
      load_p1      <= 1'b0;
      mem_req_p1   <= 1'b0;
      ld_op_p1     <= '0;
      except_p1    <= '0;
      data_seen_p1 <= 1'b0;
      buf_valid_p1 <= 1'b0;
      rdata_buf_p1 <= '0;
      discard_cnt  <= '0;
    end else begin
      if (except_flush)       vld_p1 <= 1'b0;
      else if (es.ms_allowin) vld_p1 <= es.es_to_ms_valid;

      discard_cnt <= disc_next;

      if (accept) begin
        pc_p1        <= es.es_pc;
        result_p1    <= es.es_result;
        rf_we_p1     <= es.es_rf_we;
        rf_waddr_p1  <= es.es_rf_waddr;
        load_p1      <= es.es_res_from_mem;
        mem_req_p1   <= es.es_mem_req;
        ld_op_p1     <= es.es_ld_op;
        except_p1    <= es.es_except;
        data_seen_p1 <= 1'b0;
        buf_valid_p1 <= 1'b0;
      end else if (resp_take & vld_p1 & mem_req_p1 & ~data_seen_p1) begin
        data_seen_p1 <= 1'b1;
        if (!ws_allowin) begin
          buf_valid_p1 <= 1'b1;
          rdata_buf_p1 <= data_sram_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && except_flush)
      assert (disc_sum <= (DISCARD_W+2)'(DISC_MAX))
        else $error("mem_stage_reg: discard counter overflow");
    if (resetn && es.es_to_ms_valid && (es.es_except != '0))
      assert (!es.es_mem_req)
        else $error("mem_stage_reg: memory request on excepting instruction");
  end

`ifdef MS_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    ms_stall_cnt <= '0;
    else if (vld_p1 & ~ms_ready_go) ms_stall_cnt <= ms_stall_cnt + 32'd1;
  end
`endif

endmodule
